tdm_mux: RTL and testbench
==========================

Name: tdm_mux

Overview:
Parametrised N-channel, W-bit registered multiplexer with two modes: manual select, and an automatic time-division scan that steps through channels at a programmable dwell. It generalises the course's combinational 4-to-1 mux. It adds a registered output, a one-hot (decoder) select view, a frame marker and out-of-range select detection. It sits between grouped data sources and a single serial/shared consumer.

Parameters:
W, 1, data width per channel
N, 4, number of input channels (N >= 2, need not be a power of two)
SELW, 2, select width; must satisfy 2**SELW >= N
DWELL, 1, clock cycles spent on each channel in auto mode (DWELL >= 1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
en  input  1  clock enable; 0 = all state holds
mode  input  1  0 = manual select, 1 = auto scan
sel_in  input  SELW  manual channel select
din  input  N*W  packed inputs; channel k = din[k*W +: W]
dout  output  W  registered selected data
ch_idx  output  SELW  channel currently driving dout
ch_onehot  output  N  one-hot decode of ch_idx
frame_start  output  1  one-cycle pulse when auto scan wraps to channel 0
sel_err  output  1  one-cycle flag: manual sel_in >= N was rejected

Behaviour:
- One clock domain. Reset is asynchronous, active-high (rst); clock is clk.
- Reset values: dout=0, ch_idx=0, ch_onehot=1 (bit 0), frame_start=0, sel_err=0, dwell counter=0. Reset asserted mid-scan clears immediately, without waiting for a clock edge.
- Every enabled edge computes ch_next, then: ch_idx<=ch_next, ch_onehot<=1<<ch_next, dout<=din slice of ch_next.
- dout, ch_idx and ch_onehot are always mutually consistent. Latency is 1 cycle from din/sel_in to dout.
- Manual (mode=0):
  - If sel_in<N, ch_next=sel_in, sel_err<=0.
  - If sel_in>=N, ch_next=ch_idx (hold) and sel_err<=1 for that cycle.
  - Dwell counter is forced to 0. frame_start<=0.
- Auto (mode=1):
  - Dwell counter cnt runs 0..DWELL-1.
  - If cnt==DWELL-1: cnt<=0 and ch_next = (ch_idx==N-1) ? 0 : ch_idx+1.
  - Otherwise cnt<=cnt+1 and ch_next=ch_idx. dout still re-samples din of the held channel each cycle.
  - frame_start<=1 exactly on the edge where ch_idx changes from N-1 to 0; otherwise 0. sel_in is ignored and sel_err<=0.
- DWELL=1: the channel advances every enabled cycle.
- Mode change manual->auto: the scan starts from the current ch_idx with cnt=0, so the first advance comes DWELL cycles later.
- Mode change auto->manual: takes effect on the same edge; ch_next=sel_in, cnt cleared.
- en=0: ch_idx, ch_onehot, dout and cnt hold; frame_start<=0, sel_err<=0. en is sampled with mode on the same edge.
- Non-power-of-two N: wrap is at N-1. Codes N..2**SELW-1 are never produced and are rejected in manual mode.
- Counter width: clog2(DWELL) bits, minimum 1.

Test Plan:
- Reset: assert rst mid-cycle with ch_idx=2 -> all outputs at reset values immediately (dout=0, ch_idx=0, ch_onehot=4'b0001, frame_start=0).
- Manual: W=1, N=4, din=4'b1010; sel_in 0,1,2,3 on consecutive cycles -> dout 0,1,0,1 one cycle later; ch_onehot 0001,0010,0100,1000.
- Auto scan, DWELL=1, N=4: ch_idx sequence 1,2,3,0,1 -> frame_start high only on the cycle ch_idx=0; dout tracks the matching din bit.
- Auto scan, DWELL=3: each ch_idx is held 3 cycles. Toggle din[ch] during the dwell -> dout follows with 1-cycle latency. Wrap from 3 to 0 pulses frame_start once.
- Out of range: N=5, SELW=3, manual, ch_idx=2, sel_in=6 -> ch_idx stays 2, sel_err=1 for one cycle; next sel_in=4 -> ch_idx=4, sel_err=0.
- Enable and mode switch: en=0 for 5 cycles during auto -> no change, no frame_start. Then auto->manual with sel_in=1 -> ch_idx=1 on the next edge. Then manual->auto -> first advance to 2 after DWELL cycles.

Source files
------------

// File: rtl/tdm_mux.sv
// rtl/tdm_mux.sv - N-channel registered TDM multiplexer with manual select and auto scan
//
// Purpose: selects one of N packed W-bit channels onto a registered output,
// either by a manual select code or by an automatic round-robin scan that
// dwells DWELL enabled cycles on each channel.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   en           clock enable; 0 holds all state, clears the pulse outputs
//   mode         0 = manual select, 1 = auto scan
//   sel_in       manual channel select
//   din          packed inputs, channel k = din[k*W +: W]
//   dout         registered data of the selected channel
//   ch_idx       channel currently driving dout
//   ch_onehot    one-hot decode of ch_idx
//   frame_start  one-cycle pulse when the scan wraps from N-1 to 0
//   sel_err      one-cycle flag, manual sel_in >= N was rejected
module tdm_mux #(
   parameter int W     = 1,
   parameter int N     = 4,
   parameter int SELW  = 2,
   parameter int DWELL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic [SELW-1:0]   sel_in,
   input  logic [N*W-1:0]    din,
   output logic [W-1:0]      dout,
   output logic [SELW-1:0]   ch_idx,
   output logic [N-1:0]      ch_onehot,
   output logic              frame_start,
   output logic              sel_err
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   // One extra bit so N itself is representable when N == 2**SELW.
   localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
   localparam logic [SELW-1:0] LAST_CH  = SELW'(N - 1);
   localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);

   logic [W-1:0]    dout_q,    dout_d;
   logic [SELW-1:0] ch_q,      ch_d;
   logic [N-1:0]    onehot_q,  onehot_d;
   logic [CW-1:0]   cnt_q,     cnt_d;
   logic            frame_q,   frame_d;
   logic            err_q,     err_d;

   logic [SELW-1:0] ch_next;
   logic [W-1:0]    sel_data;
   logic [N-1:0]    sel_onehot;

   always_comb begin
      ch_next  = ch_q;
      cnt_d    = cnt_q;
      frame_d  = 1'b0;
      err_d    = 1'b0;

      if (!mode) begin
         cnt_d = '0;
         if ({1'b0, sel_in} < N_EXT) begin
            ch_next = sel_in;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (ch_q == LAST_CH) begin
               ch_next = '0;
               frame_d = 1'b1;
            end else begin
               ch_next = ch_q + SELW'(1);
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      // ch_next is always < N, so exactly one branch matches.
      sel_data   = '0;
      sel_onehot = '0;
      for (int k = 0; k < N; k++) begin
         if (ch_next == SELW'(k)) begin
            sel_data      = din[k*W +: W];
            sel_onehot[k] = 1'b1;
         end
      end

      if (en) begin
         ch_d     = ch_next;
         onehot_d = sel_onehot;
         dout_d   = sel_data;
      end else begin
         ch_d     = ch_q;
         onehot_d = onehot_q;
         dout_d   = dout_q;
         cnt_d    = cnt_q;
         frame_d  = 1'b0;
         err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q   <= '0;
         ch_q     <= '0;
         onehot_q <= N'(1);
         cnt_q    <= '0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         dout_q   <= dout_d;
         ch_q     <= ch_d;
         onehot_q <= onehot_d;
         cnt_q    <= cnt_d;
         frame_q  <= frame_d;
         err_q    <= err_d;
      end
   end

   assign dout        = dout_q;
   assign ch_idx      = ch_q;
   assign ch_onehot   = onehot_q;
   assign frame_start = frame_q;
   assign sel_err     = err_q;

endmodule

// File: tb/tb_tdm_mux.sv
// tb/tb_tdm_mux.sv - directed self-checking bench for tdm_mux
module tb_tdm_mux;

   logic clk;
   logic rst;
   logic en;
   logic mode;

   // A: W=1 N=4 DWELL=1
   logic [1:0]  sel_a;
   logic [3:0]  din_a;
   logic [0:0]  dout_a;
   logic [1:0]  ch_a;
   logic [3:0]  oh_a;
   logic        fs_a, err_a;

   // B: W=1 N=4 DWELL=3
   logic [1:0]  sel_b;
   logic [3:0]  din_b;
   logic [0:0]  dout_b;
   logic [1:0]  ch_b;
   logic [3:0]  oh_b;
   logic        fs_b, err_b;

   // C: W=4 N=5 SELW=3 DWELL=2
   logic [2:0]  sel_c;
   logic [19:0] din_c;
   logic [3:0]  dout_c;
   logic [2:0]  ch_c;
   logic [4:0]  oh_c;
   logic        fs_c, err_c;

   int total;
   int bad;

   tdm_mux #(.W(1), .N(4), .SELW(2), .DWELL(1)) u_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_a), .din(din_a),
      .dout(dout_a), .ch_idx(ch_a), .ch_onehot(oh_a), .frame_start(fs_a), .sel_err(err_a)
   );

   tdm_mux #(.W(1), .N(4), .SELW(2), .DWELL(3)) u_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_b), .din(din_b),
      .dout(dout_b), .ch_idx(ch_b), .ch_onehot(oh_b), .frame_start(fs_b), .sel_err(err_b)
   );

   tdm_mux #(.W(4), .N(5), .SELW(3), .DWELL(2)) u_c (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_c), .din(din_c),
      .dout(dout_c), .ch_idx(ch_c), .ch_onehot(oh_c), .frame_start(fs_c), .sel_err(err_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_ch;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      en    = 1'b0;
      mode  = 1'b0;
      sel_a = '0; sel_b = '0; sel_c = '0;
      din_a = '0; din_b = '0;
      din_c = {4'hE, 4'hD, 4'hC, 4'hB, 4'hA};

      #2;
      chk("rst_dout", 32'(dout_a), 32'd0);
      chk("rst_ch", 32'(ch_a), 32'd0);
      chk("rst_onehot", 32'(oh_a), 32'b0001);
      chk("rst_frame", 32'(fs_a), 32'd0);
      chk("rst_err", 32'(err_a), 32'd0);
      chk("rst_onehot_c", 32'(oh_c), 32'b00001);

      step();
      rst = 1'b0;

      // asynchronous reset mid-cycle with ch_idx=2
      en = 1'b1; sel_a = 2'd2; din_a = 4'b0100;
      step();
      chk("pre_rst_ch", 32'(ch_a), 32'd2);
      chk("pre_rst_dout", 32'(dout_a), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_dout", 32'(dout_a), 32'd0);
      chk("async_rst_ch", 32'(ch_a), 32'd0);
      chk("async_rst_onehot", 32'(oh_a), 32'b0001);
      chk("async_rst_frame", 32'(fs_a), 32'd0);
      #1 rst = 1'b0;

      // manual select over din=1010
      din_a = 4'b1010;
      sel_a = 2'd0; step();
      chk("man0_dout", 32'(dout_a), 32'd0);
      chk("man0_oh", 32'(oh_a), 32'b0001);
      sel_a = 2'd1; step();
      chk("man1_dout", 32'(dout_a), 32'd1);
      chk("man1_oh", 32'(oh_a), 32'b0010);
      sel_a = 2'd2; step();
      chk("man2_dout", 32'(dout_a), 32'd0);
      chk("man2_oh", 32'(oh_a), 32'b0100);
      sel_a = 2'd3; step();
      chk("man3_dout", 32'(dout_a), 32'd1);
      chk("man3_oh", 32'(oh_a), 32'b1000);
      chk("man3_err", 32'(err_a), 32'd0);

      // auto scan DWELL=1 from channel 0: 1,2,3,0,1
      sel_a = 2'd0; step();
      chk("a_start_ch", 32'(ch_a), 32'd0);
      mode = 1'b1;
      step();
      chk("a1_ch", 32'(ch_a), 32'd1); chk("a1_fs", 32'(fs_a), 32'd0); chk("a1_dout", 32'(dout_a), 32'd1);
      step();
      chk("a2_ch", 32'(ch_a), 32'd2); chk("a2_fs", 32'(fs_a), 32'd0); chk("a2_dout", 32'(dout_a), 32'd0);
      step();
      chk("a3_ch", 32'(ch_a), 32'd3); chk("a3_fs", 32'(fs_a), 32'd0); chk("a3_dout", 32'(dout_a), 32'd1);
      step();
      chk("a0_ch", 32'(ch_a), 32'd0); chk("a0_fs", 32'(fs_a), 32'd1); chk("a0_dout", 32'(dout_a), 32'd0);
      chk("a0_oh", 32'(oh_a), 32'b0001);
      step();
      chk("a1b_ch", 32'(ch_a), 32'd1); chk("a1b_fs", 32'(fs_a), 32'd0); chk("a1b_dout", 32'(dout_a), 32'd1);

      // auto scan DWELL=3: park B on channel 0, then scan
      mode = 1'b0; sel_b = 2'd0; step();
      chk("b_start_ch", 32'(ch_b), 32'd0);
      mode = 1'b1; din_b = 4'b0001; step();
      chk("b1_ch", 32'(ch_b), 32'd0); chk("b1_dout", 32'(dout_b), 32'd1);
      din_b = 4'b0000; step();
      chk("b2_ch", 32'(ch_b), 32'd0); chk("b2_dout", 32'(dout_b), 32'd0);
      din_b = 4'b0010; step();
      chk("b3_ch", 32'(ch_b), 32'd1); chk("b3_dout", 32'(dout_b), 32'd1);
      chk("b3_oh", 32'(oh_b), 32'b0010);
      din_b = 4'b1010;
      for (int s = 4; s <= 13; s++) begin
         step();
         exp_ch = 2'((s / 3) % 4);
         chk($sformatf("b%0d_ch", s), 32'(ch_b), 32'(exp_ch));
         chk($sformatf("b%0d_fs", s), 32'(fs_b), (s == 12) ? 32'd1 : 32'd0);
         chk($sformatf("b%0d_dout", s), 32'(dout_b), 32'(din_b[exp_ch]));
      end

      // enable low for 5 cycles mid-scan
      en = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step();
         chk($sformatf("en0_%0d_ch", s), 32'(ch_b), 32'd0);
         chk($sformatf("en0_%0d_fs", s), 32'(fs_b), 32'd0);
      end

      // auto -> manual on the same edge, then manual -> auto
      en = 1'b1; mode = 1'b0; sel_b = 2'd1; step();
      chk("sw_man_ch", 32'(ch_b), 32'd1);
      chk("sw_man_dout", 32'(dout_b), 32'd1);
      mode = 1'b1; step();
      chk("sw_auto1_ch", 32'(ch_b), 32'd1);
      step();
      chk("sw_auto2_ch", 32'(ch_b), 32'd1);
      step();
      chk("sw_auto3_ch", 32'(ch_b), 32'd2);
      chk("sw_auto3_oh", 32'(oh_b), 32'b0100);

      // out of range select, N=5
      mode = 1'b0; sel_c = 3'd2; step();
      chk("c2_ch", 32'(ch_c), 32'd2); chk("c2_err", 32'(err_c), 32'd0); chk("c2_dout", 32'(dout_c), 32'hC);
      sel_c = 3'd6; step();
      chk("c6_ch", 32'(ch_c), 32'd2); chk("c6_err", 32'(err_c), 32'd1); chk("c6_dout", 32'(dout_c), 32'hC);
      sel_c = 3'd4; step();
      chk("c4_ch", 32'(ch_c), 32'd4); chk("c4_err", 32'(err_c), 32'd0);
      chk("c4_oh", 32'(oh_c), 32'b10000); chk("c4_dout", 32'(dout_c), 32'hE);
      sel_c = 3'd5; step();
      chk("c5_ch", 32'(ch_c), 32'd4); chk("c5_err", 32'(err_c), 32'd1);

      // auto wrap at N-1=4 with DWELL=2
      mode = 1'b1; step();
      chk("cw1_ch", 32'(ch_c), 32'd4); chk("cw1_err", 32'(err_c), 32'd0); chk("cw1_fs", 32'(fs_c), 32'd0);
      step();
      chk("cw2_ch", 32'(ch_c), 32'd0); chk("cw2_fs", 32'(fs_c), 32'd1); chk("cw2_dout", 32'(dout_c), 32'hA);
      step();
      chk("cw3_ch", 32'(ch_c), 32'd0); chk("cw3_fs", 32'(fs_c), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
